// File: rtl/nav_pkg.sv
// nav_pkg: FSM encoding, button indices and view-coordinate limits shared by the navigation controller.
// Limit helpers take the fractional width so the controller can be built at other precisions.
package nav_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_UPDATE,
      ST_START,
      ST_WAIT
   } nav_state_e;

   localparam int NAV_BTN_N   = 6;
   localparam int BTN_UP      = 0;
   localparam int BTN_DOWN    = 1;
   localparam int BTN_LEFT    = 2;
   localparam int BTN_RIGHT   = 3;
   localparam int BTN_ZOOMIN  = 4;
   localparam int BTN_ZOOMOUT = 5;

   localparam int NAV_FRAC_W   = 24;
   localparam int NAV_INT_BITS = 3;

   // +2.0 - 1 lsb
   function automatic logic signed [63:0] coord_pos_lim(input int frac_w);
      return (64'sd1 <<< (frac_w + 1)) - 64'sd1;
   endfunction

   // -2.0
   function automatic logic signed [63:0] coord_neg_lim(input int frac_w);
      return -(64'sd1 <<< (frac_w + 1));
   endfunction

   // -0.5, the reset real-axis centre
   function automatic logic signed [63:0] coord_rst_x(input int frac_w);
      return -(64'sd1 <<< (frac_w - 1));
   endfunction

endpackage

// File: rtl/nav_repeat_timer.sv
// nav_repeat_timer: fires a one-cycle pulse after a non-zero button vector has been held DELAY cycles,
// then every PERIOD cycles while it stays unchanged; any change of the vector restarts the count.
module nav_repeat_timer
   import nav_pkg::*;
#(
   parameter int DELAY  = 25_000_000,
   parameter int PERIOD = 5_000_000
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [NAV_BTN_N-1:0] held_i,
   output logic                 fire_o
);

   localparam int MAXV = (DELAY > PERIOD) ? DELAY : PERIOD;
   localparam int TW   = $clog2(MAXV) + 1;
   localparam logic [TW-1:0] DLY_LAST = TW'(DELAY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(PERIOD - 1);

   logic [NAV_BTN_N-1:0] prev_q;
   logic [TW-1:0]        cnt_q, cnt_d;
   logic                 rep_q, rep_d;
   logic                 stable;

   assign stable = (held_i != '0) && (held_i == prev_q);

   always_comb begin
      cnt_d  = '0;
      rep_d  = 1'b0;
      fire_o = 1'b0;
      if (stable) begin
         rep_d = rep_q;
         if (cnt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
            fire_o = 1'b1;
            cnt_d  = '0;
            rep_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         prev_q <= '1;
         cnt_q  <= '0;
         rep_q  <= 1'b0;
      end else begin
         prev_q <= held_i;
         cnt_q  <= cnt_d;
         rep_q  <= rep_d;
      end
   end

endmodule

// File: rtl/nav_view_ctrl.sv
// nav_view_ctrl: turns button presses into one pan/zoom action at a time and sequences the renderer.
// Press -> Start in 3 edges; view frozen from Start until Done. NAV_AUTOREPEAT_EN adds held-button repeat.
module nav_view_ctrl
   import nav_pkg::*;
#(
   parameter int FRAC_W        = NAV_FRAC_W,
   parameter int MAX_ZOOM      = 20,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic                                     Clk,
   input  logic                                     Rst,
   input  logic [NAV_BTN_N-1:0]                     Btn,
   input  logic                                     Done,
   output logic                                     Start,
   output logic                                     Busy,
   output logic signed [FRAC_W+NAV_INT_BITS-1:0]    CenterX,
   output logic signed [FRAC_W+NAV_INT_BITS-1:0]    CenterY,
   output logic [4:0]                               Zoom
);

   localparam int CW = FRAC_W + NAV_INT_BITS;
   localparam logic signed [CW-1:0] POS_LIM = CW'(coord_pos_lim(FRAC_W));
   localparam logic signed [CW-1:0] NEG_LIM = CW'(coord_neg_lim(FRAC_W));
   localparam logic signed [CW:0]   POS_EXT = (CW + 1)'(coord_pos_lim(FRAC_W));
   localparam logic signed [CW:0]   NEG_EXT = (CW + 1)'(coord_neg_lim(FRAC_W));
   localparam logic signed [CW-1:0] RST_X   = CW'(coord_rst_x(FRAC_W));
   localparam logic [CW-1:0]        STEP0   = CW'(64'd1 << (FRAC_W - 3));
   localparam logic [4:0]           ZMAX    = 5'(MAX_ZOOM);

   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("nav_view_ctrl: repeat delay and period must be at least 1");
   end

   nav_state_e            state_q, state_d;
   logic [NAV_BTN_N-1:0]  btn_q, pend_q, pend_d, rise, clr, rpt_set;
   logic signed [CW-1:0]  cx_q, cx_d, cy_q, cy_d;
   logic [4:0]            zoom_q, zoom_d;
   logic                  start_q, busy_q;
   logic [CW-1:0]         step;
   logic signed [CW:0]    cx_ext, cy_ext, step_ext;

   function automatic logic signed [CW-1:0] sat(input logic signed [CW:0] v);
      if (v > POS_EXT) return POS_LIM;
      if (v < NEG_EXT) return NEG_LIM;
      return v[CW-1:0];
   endfunction

`ifdef NAV_AUTOREPEAT_EN
   logic rpt_fire;

   nav_repeat_timer #(
      .DELAY  (REPEAT_DELAY),
      .PERIOD (REPEAT_PERIOD)
   ) u_repeat (
      .Clk    (Clk),
      .Rst    (Rst),
      .held_i (Btn),
      .fire_o (rpt_fire)
   );

   assign rpt_set = rpt_fire ? Btn : '0;
`else
   assign rpt_set = '0;
`endif

   assign rise     = Btn & ~btn_q;
   assign step     = STEP0 >> zoom_q;
   assign step_ext = {1'b0, step};
   assign cx_ext   = {cx_q[CW-1], cx_q};
   assign cy_ext   = {cy_q[CW-1], cy_q};

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      zoom_d  = zoom_q;
      clr     = '0;
      case (state_q)
         ST_INIT:  state_d = ST_START;
         ST_IDLE:  if (pend_q != '0) state_d = ST_UPDATE;
         ST_UPDATE: begin
            // Priority order: ZoomIn, ZoomOut, Up, Down, Left, Right.
            if (pend_q[BTN_ZOOMIN]) begin
               clr[BTN_ZOOMIN] = 1'b1;
               if (zoom_q < ZMAX) zoom_d = zoom_q + 5'd1;
            end else if (pend_q[BTN_ZOOMOUT]) begin
               clr[BTN_ZOOMOUT] = 1'b1;
               if (zoom_q != 5'd0) zoom_d = zoom_q - 5'd1;
            end else if (pend_q[BTN_UP]) begin
               clr[BTN_UP] = 1'b1;
               cy_d = sat(cy_ext + step_ext);
            end else if (pend_q[BTN_DOWN]) begin
               clr[BTN_DOWN] = 1'b1;
               cy_d = sat(cy_ext - step_ext);
            end else if (pend_q[BTN_LEFT]) begin
               clr[BTN_LEFT] = 1'b1;
               cx_d = sat(cx_ext - step_ext);
            end else if (pend_q[BTN_RIGHT]) begin
               clr[BTN_RIGHT] = 1'b1;
               cx_d = sat(cx_ext + step_ext);
            end
            state_d = ((cx_d != cx_q) || (cy_d != cy_q) || (zoom_d != zoom_q)) ? ST_START : ST_IDLE;
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (Done) state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
      // A new press on the bit being consumed survives the clear.
      pend_d = (pend_q & ~clr) | rise | rpt_set;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_INIT;
         btn_q   <= '1;
         pend_q  <= '0;
         cx_q    <= RST_X;
         cy_q    <= '0;
         zoom_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         btn_q   <= Btn;
         pend_q  <= pend_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         zoom_q  <= zoom_d;
         start_q <= (state_d == ST_START);
         busy_q  <= (state_d == ST_START) || (state_d == ST_WAIT);
      end
   end

   assign Start   = start_q;
   assign Busy    = busy_q;
   assign CenterX = cx_q;
   assign CenterY = cy_q;
   assign Zoom    = zoom_q;

endmodule

// File: tb/tb_nav_view_ctrl.sv
// tb_nav_view_ctrl: directed vectors and hand-written sequences for the navigation controller.
module tb_nav_view_ctrl;

   localparam int STEP = 1 << 21;
   localparam int RX   = -(1 << 23);
   localparam int POS  = (1 << 25) - 1;
   localparam int NEG  = -(1 << 25);
`ifdef NAV_AUTOREPEAT_EN
   localparam int EXP_RPT = 6;
`else
   localparam int EXP_RPT = 1;
`endif

   logic               Clk = 1'b0;
   logic               Rst, Done, Start, Busy;
   logic [5:0]         Btn;
   logic signed [26:0] CenterX, CenterY;
   logic [4:0]         Zoom;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;

   typedef struct {
      logic [5:0] btn;
      int         starts;
      int         cx;
      int         cy;
      int         zoom;
   } vec_t;

   vec_t vecs[8];

   nav_view_ctrl #(
      .FRAC_W        (24),
      .MAX_ZOOM      (20),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (4)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .Btn     (Btn),
      .Done    (Done),
      .Start   (Start),
      .Busy    (Busy),
      .CenterX (CenterX),
      .CenterY (CenterY),
      .Zoom    (Zoom)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
      if (Start) start_cnt++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      Rst = 1'b1;
      Btn = '0;
      Done = 1'b0;
      tick();
      tick();
      Rst = 1'b0;
   endtask

   task automatic finish_init();
      tick();
      tick();
      Done = 1'b1;
      tick();
      Done = 1'b0;
      tick();
      start_cnt = 0;
   endtask

   task automatic press(input logic [5:0] b, output int n);
      int s0;
      s0 = start_cnt;
      Btn = b;
      tick();
      Btn = '0;
      repeat (4) tick();
      Done = 1'b1;
      tick();
      Done = 1'b0;
      tick();
      n = start_cnt - s0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, acc, s0;

      vecs[0] = '{6'h10, 1, RX,                0,    1};
      vecs[1] = '{6'h08, 1, RX + (STEP >> 1),  0,    1};
      vecs[2] = '{6'h20, 1, RX + (STEP >> 1),  0,    0};
      vecs[3] = '{6'h20, 0, RX + (STEP >> 1),  0,    0};
      vecs[4] = '{6'h01, 1, RX + (STEP >> 1),  STEP, 0};
      vecs[5] = '{6'h02, 1, RX + (STEP >> 1),  0,    0};
      vecs[6] = '{6'h04, 1, RX - (STEP >> 1),  0,    0};
      vecs[7] = '{6'h08, 1, RX + (STEP >> 1),  0,    0};

      // Reset values and the initial render.
      Rst = 1'b1; Btn = '1; Done = 1'b0;
      tick(); tick();
      Btn = '0;
      check("rst_cx", CenterX, RX);
      check("rst_cy", CenterY, 0);
      check("rst_zoom", Zoom, 0);
      check("rst_start", Start, 0);
      check("rst_busy", Busy, 0);
      Rst = 1'b0;
      tick();
      check("init_start", Start, 1);
      tick();
      check("init_start_once", Start, 0);
      check("init_busy", Busy, 1);
      repeat (3) tick();
      check("init_busy_hold", Busy, 1);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("init_busy_drop", Busy, 0);
      check("init_start_cnt", start_cnt, 1);
      tick();

      // Single actions from the table.
      for (int i = 0; i < 8; i++) begin
         press(vecs[i].btn, n);
         check($sformatf("v%0d_starts", i), n, vecs[i].starts);
         check($sformatf("v%0d_cx", i), CenterX, vecs[i].cx);
         check($sformatf("v%0d_cy", i), CenterY, vecs[i].cy);
         check($sformatf("v%0d_zoom", i), Zoom, vecs[i].zoom);
      end

      // Press-to-Start latency; Done during the Start cycle is ignored.
      Btn = 6'h10;
      tick();
      Btn = '0;
      check("lat_t0", Start, 0);
      tick();
      check("lat_t1", Start, 0);
      tick();
      check("lat_t2", Start, 1);
      check("lat_zoom", Zoom, 1);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("done_in_start_busy", Busy, 1);
      tick();
      Done = 1'b1;
      tick();
      Done = 1'b0;
      check("lat_busy_drop", Busy, 0);
      tick();

      // Up and ZoomOut pressed together during WAIT.
      apply_reset();
      tick(); tick();
      Btn = 6'h21;
      tick();
      Btn = '0;
      tick(); tick();
      check("both_wait_busy", Busy, 1);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      s0 = start_cnt;
      tick(); tick();
      check("both_no_early_start", Start, 0);
      tick(); tick();
      check("both_up_start", Start, 1);
      repeat (6) tick();
      check("both_starts", start_cnt - s0, 1);
      check("both_cy", CenterY, STEP);
      check("both_zoom", Zoom, 0);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      tick();

      // Left saturation at -2.0, then a Right proves the Left bit was consumed.
      apply_reset();
      finish_init();
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         press(6'h04, n);
         acc += n;
      end
      check("left_starts", acc, 12);
      check("left_sat_cx", CenterX, NEG);
      press(6'h08, n);
      check("left_then_right_starts", n, 1);
      check("left_then_right_cx", CenterX, NEG + STEP);

      // Right saturation at +2.0 - lsb.
      acc = 0;
      for (int i = 0; i < 32; i++) begin
         press(6'h08, n);
         acc += n;
      end
      check("right_starts", acc, 31);
      check("right_sat_cx", CenterX, POS);

      // ZoomIn saturation at MAX_ZOOM.
      acc = 0;
      for (int i = 0; i < 21; i++) begin
         press(6'h10, n);
         acc += n;
      end
      check("zoom_starts", acc, 20);
      check("zoom_sat", Zoom, 20);

      // Reset in WAIT with a pending press; stale Done must not end the fresh render early.
      Btn = 6'h01;
      tick();
      Btn = '0;
      tick(); tick(); tick();
      Btn = 6'h02;
      tick();
      Btn = '0;
      tick();
      Rst = 1'b1;
      tick();
      check("midrst_cx", CenterX, RX);
      check("midrst_cy", CenterY, 0);
      check("midrst_zoom", Zoom, 0);
      check("midrst_busy", Busy, 0);
      Rst = 1'b0;
      Done = 1'b1;
      s0 = start_cnt;
      tick();
      Done = 1'b0;
      check("midrst_init_start", Start, 1);
      tick();
      check("midrst_busy_start", Busy, 1);
      tick();
      check("midrst_busy_wait", Busy, 1);
      Done = 1'b1;
      tick();
      Done = 1'b0;
      repeat (6) tick();
      check("midrst_starts", start_cnt - s0, 1);
      check("midrst_pend_cleared_cy", CenterY, 0);

      // Held Up with Done tied high.
      apply_reset();
      finish_init();
      Done = 1'b1;
      Btn = 6'h01;
      repeat (30) tick();
      Btn = '0;
      repeat (20) tick();
      Done = 1'b0;
      tick();
      check("hold_starts", start_cnt, EXP_RPT);
      check("hold_cy", CenterY, EXP_RPT * STEP);
      check("hold_busy", Busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
